exu_trap_ctrl: RTL
==================

Name: exu_trap_ctrl

Overview:
- Trap/return controller directly downstream of the exception unit in the NPC execute stage.
- Consumes the commit trap pulse and cause, and updates the machine trap CSRs (mstatus, mtvec, mepc, mcause).
- Issues a handshaked pipeline flush with redirect PC to the IFU, handles mret, and parks the core in a halt state on ebreak.

Parameters:
- XLEN, 32, datapath/CSR width.
- RESET_MTVEC, 32'h8000_0000, mtvec value after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- cmt_trap_i  input  1  trap commit pulse from exception unit
- cmt_cause_i  input  XLEN  trap cause code
- cmt_pc_i  input  XLEN  PC of trapping or mret instruction
- cmt_mret_i  input  1  mret commit pulse
- cmt_ready_o  output  1  controller can accept trap/mret
- csr_wr_en_i  input  1  CSR write strobe
- csr_idx_i  input  12  CSR address
- csr_wdata_i  input  XLEN  CSR write data
- csr_rdata_o  output  XLEN  CSR read data (combinational on csr_idx_i)
- flush_req_o  output  1  flush request to IFU
- flush_ack_i  input  1  IFU accepts flush
- flush_pc_o  output  XLEN  redirect target, valid while flush_req_o
- halted_o  output  1  core stopped by ebreak

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, flush_req_o=0, flush_pc_o=0, halted_o=0, cmt_ready_o=1, mepc=0, mcause=0, mtvec=RESET_MTVEC, mstatus=32'h0000_1800 (MPP=2'b11, MIE=0, MPIE=0).
  - Reset mid-FLUSH or in HALT returns to IDLE on the next edge and drops flush_req_o.
- CSR map (all others: reads return 0, writes are dropped):
  - mstatus 0x300. Only MIE[3], MPIE[7] and MPP[12:11] exist. MPP always reads 2'b11. Other bits read 0.
  - mtvec 0x305. Direct mode only; bits[1:0] are forced to 0 on write.
  - mepc 0x341. Bits[1:0] are forced to 0 on write.
  - mcause 0x342. Full width.
- CSR writes:
  - Take effect at the next edge, only in IDLE. In other states they are ignored.
- FSM states: IDLE, FLUSH, HALT.
  - cmt_ready_o=1 only in IDLE.
- IDLE, cmt_trap_i=1 (trap has priority over cmt_mret_i and over a same-cycle CSR write to the same register):
  - mepc <= {cmt_pc_i[XLEN-1:2],2'b00}
  - mcause <= cmt_cause_i
  - MPIE <= MIE, MIE <= 0
  - If cmt_cause_i==3 (ebreak): go to HALT and do not assert a flush.
  - Otherwise: flush_pc_o <= mtvec, go to FLUSH.
  - A same-cycle CSR write to mtvec is applied, but flush_pc_o uses the pre-write mtvec.
- IDLE, cmt_mret_i=1 (no trap):
  - flush_pc_o <= mepc (pre-write value)
  - MIE <= MPIE, MPIE <= 1
  - Go to FLUSH.
- FLUSH:
  - flush_req_o=1, with flush_pc_o held stable.
  - On a cycle with flush_ack_i=1, go to IDLE; flush_req_o=0 from the next cycle.
  - Latency: trap to flush_req_o is 1 cycle. With ack in the first FLUSH cycle, a new trap is accepted 2 cycles after the original.
  - cmt_trap_i/cmt_mret_i arriving in FLUSH are ignored. Upstream must honour cmt_ready_o.
- HALT:
  - halted_o=1, flush_req_o=0.
  - All commits and CSR writes are ignored. Only rst exits HALT.
- flush_ack_i outside FLUSH has no effect.

Test Plan:
- Reset, then read 0x300/0x305/0x341/0x342 -> 0x1800, 0x8000_0000, 0, 0; cmt_ready_o=1.
- IDLE, MIE=1, trap pulse with cause=11, pc=0x8000_0106 -> next cycle mepc=0x8000_0104, mcause=11, mstatus=0x1880, flush_req_o=1, flush_pc_o=0x8000_0000. Hold ack low for 3 cycles -> req and pc stable. Ack -> IDLE.
- After the previous case, mret pulse -> flush_pc_o=0x8000_0104, mstatus reads 0x1888. Ack -> IDLE.
- Trap cause=3 -> halted_o=1, flush_req_o stays 0. Further trap, mret and CSR write are ignored. rst -> halted_o=0.
- Same cycle: trap cause=2 plus CSR write mtvec=0x8000_0203 -> flush_pc_o=old mtvec, then mtvec reads 0x8000_0200. Trap+mret together -> trap path only.
- Assert rst while in FLUSH with ack low -> next cycle flush_req_o=0, cmt_ready_o=1, all CSRs at reset values.

Source files
------------

// File: rtl/exu_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exu_trap_ctrl
// Brief    : Machine trap/mret controller: trap CSRs, IFU flush handshake, ebreak halt.
// Revision : 1.0
// ============================================================================
module exu_trap_ctrl #(
   parameter int                XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_MTVEC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmt_trap_i,
   input  logic [XLEN-1:0]  cmt_cause_i,
   input  logic [XLEN-1:0]  cmt_pc_i,
   input  logic             cmt_mret_i,
   output logic             cmt_ready_o,
   input  logic             csr_wr_en_i,
   input  logic [11:0]      csr_idx_i,
   input  logic [XLEN-1:0]  csr_wdata_i,
   output logic [XLEN-1:0]  csr_rdata_o,
   output logic             flush_req_o,
   input  logic             flush_ack_i,
   output logic [XLEN-1:0]  flush_pc_o,
   output logic             halted_o
);

   localparam logic [11:0]     c_MSTATUS      = 12'h300;
   localparam logic [11:0]     c_MTVEC        = 12'h305;
   localparam logic [11:0]     c_MEPC         = 12'h341;
   localparam logic [11:0]     c_MCAUSE       = 12'h342;
   localparam logic [XLEN-1:0] c_CAUSE_EBREAK = XLEN'(3);
   localparam logic [XLEN-1:0] c_ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_mie;
   logic             r_mpie;
   logic [XLEN-1:0]  r_mtvec;
   logic [XLEN-1:0]  r_mepc;
   logic [XLEN-1:0]  r_mcause;
   logic             r_flush_req;
   logic [XLEN-1:0]  r_flush_pc;
   logic             r_halted;
   logic             r_ready;
   logic [XLEN-1:0]  w_mstatus;

   // MPP is hardwired to machine mode; it has no storage behind it.
   always_comb begin
      w_mstatus        = '0;
      w_mstatus[3]     = r_mie;
      w_mstatus[7]     = r_mpie;
      w_mstatus[12:11] = 2'b11;
   end

   always_comb begin
      csr_rdata_o = '0;
      case (csr_idx_i)
         c_MSTATUS: csr_rdata_o = w_mstatus;
         c_MTVEC:   csr_rdata_o = r_mtvec;
         c_MEPC:    csr_rdata_o = r_mepc;
         c_MCAUSE:  csr_rdata_o = r_mcause;
         default:   csr_rdata_o = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mie       <= 1'b0;
         r_mpie      <= 1'b0;
         r_mtvec     <= RESET_MTVEC;
         r_mepc      <= '0;
         r_mcause    <= '0;
         r_flush_req <= 1'b0;
         r_flush_pc  <= '0;
         r_halted    <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (csr_wr_en_i) begin
                  case (csr_idx_i)
                     c_MSTATUS: begin
                        r_mie  <= csr_wdata_i[3];
                        r_mpie <= csr_wdata_i[7];
                     end
                     c_MTVEC:  r_mtvec  <= csr_wdata_i & c_ALIGN_MASK;
                     c_MEPC:   r_mepc   <= csr_wdata_i & c_ALIGN_MASK;
                     c_MCAUSE: r_mcause <= csr_wdata_i;
                     default:  ;
                  endcase
               end
               // Commit updates are placed after the CSR write so they win on conflict.
               if (cmt_trap_i) begin
                  r_mepc   <= cmt_pc_i & c_ALIGN_MASK;
                  r_mcause <= cmt_cause_i;
                  r_mpie   <= r_mie;
                  r_mie    <= 1'b0;
                  r_ready  <= 1'b0;
                  if (cmt_cause_i == c_CAUSE_EBREAK) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state     <= S_FLUSH;
                     r_flush_req <= 1'b1;
                     r_flush_pc  <= r_mtvec;
                  end
               end else if (cmt_mret_i) begin
                  r_mie       <= r_mpie;
                  r_mpie      <= 1'b1;
                  r_ready     <= 1'b0;
                  r_state     <= S_FLUSH;
                  r_flush_req <= 1'b1;
                  r_flush_pc  <= r_mepc;
               end
            end
            S_FLUSH: begin
               if (flush_ack_i) begin
                  r_state     <= S_IDLE;
                  r_flush_req <= 1'b0;
                  r_ready     <= 1'b1;
               end
            end
            S_HALT: ;
            default: begin
               r_state     <= S_IDLE;
               r_flush_req <= 1'b0;
               r_halted    <= 1'b0;
               r_ready     <= 1'b1;
            end
         endcase
      end
   end

   assign cmt_ready_o = r_ready;
   assign flush_req_o = r_flush_req;
   assign flush_pc_o  = r_flush_pc;
   assign halted_o    = r_halted;

endmodule
`default_nettype wire
